// File: rtl/rv32i_pkg.sv
// Shared RV32 definitions for the data-memory sequencing path.
// Holds the controller state encoding, load/store funct3 codes and a size helper.
// No logic of its own; imported by dmem_ctrl and dmem_lane_align.
package rv32i_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_WR0  = 3'd2,
        ST_RD1  = 3'd3,
        ST_WR1  = 3'd4,
        ST_RSP  = 3'd5
    } dmem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Memory is always asked for a full doubleword; merging is done here.
    localparam logic [2:0] DMEM_F3_DWORD = 3'b011;

    // Byte count encoded by funct3[1:0] (00->1, 01->2, 10->4).
    function automatic logic [3:0] f3_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte lane steering: store merge into two doubleword beats, load extract + extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module dmem_lane_align
    import rv32i_pkg::*;
#(
    parameter int MLEN = 64,
    parameter int XLEN = 32
) (
    input  logic [2:0]      off,
    input  logic [1:0]      size,
    input  logic            zext,
    input  logic [XLEN-1:0] wdata,
    input  logic [MLEN-1:0] buf0,
    input  logic [MLEN-1:0] buf1,
    input  logic [MLEN-1:0] ld_lo,
    input  logic [MLEN-1:0] ld_hi,
    output logic [MLEN-1:0] beat0,
    output logic [MLEN-1:0] beat1,
    output logic [XLEN-1:0] ld_data
);

    localparam int MB = MLEN / 8;
    localparam int XB = XLEN / 8;

    logic [2*MLEN-1:0] pair;
    logic [XLEN-1:0]   raw;
    int                nbytes;
    int                pos;

    assign pair   = {ld_hi, ld_lo};
    assign nbytes = int'(f3_bytes(size));

    // Store byte k lands at o+k; positions past the doubleword spill into beat 1.
    always_comb begin
        beat0 = buf0;
        beat1 = buf1;
        pos   = 0;
        for (int k = 0; k < XB; k++) begin
            if (k < nbytes) begin
                pos = int'(off) + k;
                if (pos < MB)
                    beat0[pos*8 +: 8] = wdata[k*8 +: 8];
                else
                    beat1[(pos-MB)*8 +: 8] = wdata[k*8 +: 8];
            end
        end
    end

    // Load bytes are taken from the concatenated pair starting at the offset.
    always_comb begin
        raw = XLEN'(pair >> {off, 3'b000});
    end

    // Extend from the top bit of the accessed size; zext picks LBU/LHU behaviour.
    always_comb begin
        case (size)
            2'b00:   ld_data = {{(XLEN-8){~zext & raw[7]}}, raw[7:0]};
            2'b01:   ld_data = {{(XLEN-16){~zext & raw[15]}}, raw[15:0]};
            default: ld_data = raw;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Sequences RV32 loads/stores into aligned 64-bit reads/writes (RMW, split beats).
// Latency accept->rsp: err 1, load 2/3 (split), store 3/5 (split).
// Backpressure: req_ready only in IDLE; rsp_valid is a one-cycle strobe, no stall.
module dmem_ctrl
    import rv32i_pkg::*;
#(
    parameter int MEM_WIDTH = 15,
    parameter int MLEN      = 64,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 rsp_valid,
    output logic [XLEN-1:0]      rsp_rdata,
    output logic                 rsp_error,
    output logic [MEM_WIDTH-1:0] mem_addr,
    output logic [2:0]           mem_funct3,
    input  logic [MLEN-1:0]      mem_rd_data,
    output logic [MLEN-1:0]      mem_wr_data,
    output logic                 mem_wr_en
);

    localparam int DW = MEM_WIDTH - 3;

    dmem_state_t     state, state_nxt;
    logic            lat_we;
    logic [2:0]      lat_f3;
    logic [2:0]      lat_off;
    logic [DW-1:0]   lat_dw;
    logic [DW-1:0]   dw_next;
    logic [XLEN-1:0] lat_wdata;
    logic            lat_split;
    logic [MLEN-1:0] buf0, buf1;
    logic [MLEN-1:0] ld_lo, ld_hi;
    logic [MLEN-1:0] beat0, beat1;
    logic [XLEN-1:0] ld_data;
    logic            acc_split;
    logic            acc_err;

    // Classify the incoming request: split detection and every reject reason.
    always_comb begin
        acc_split = ({1'b0, req_addr[2:0]} + f3_bytes(req_funct3[1:0])) > 4'd8;
        acc_err   = (req_funct3[1:0] == 2'b11)
                  || (req_funct3 == 3'b110) || (req_funct3 == 3'b111)
                  || (req_we && req_funct3[2])
                  || (|req_addr[31:MEM_WIDTH])
                  || (acc_split && (&req_addr[MEM_WIDTH-1:3]));
    end

    // Next-state: loads read one or two beats, stores read-then-write each beat.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) state_nxt = acc_err ? ST_RSP : ST_RD0;
            ST_RD0:  state_nxt = lat_we ? ST_WR0 : (lat_split ? ST_RD1 : ST_RSP);
            ST_WR0:  state_nxt = lat_split ? ST_RD1 : ST_RSP;
            ST_RD1:  state_nxt = lat_we ? ST_WR1 : ST_RSP;
            ST_WR1:  state_nxt = ST_RSP;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset drops straight back to IDLE even mid-access.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    assign dw_next = lat_dw + {{(DW-1){1'b0}}, 1'b1};

    // Request latches, read buffers, address register and registered response.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            lat_we    <= 1'b0;
            lat_f3    <= 3'b000;
            lat_off   <= 3'b000;
            lat_dw    <= '0;
            lat_wdata <= '0;
            lat_split <= 1'b0;
            buf0      <= '0;
            buf1      <= '0;
            mem_addr  <= '0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_f3    <= req_funct3;
                lat_off   <= req_addr[2:0];
                lat_dw    <= req_addr[MEM_WIDTH-1:3];
                lat_wdata <= req_wdata;
                lat_split <= acc_split;
                // Rejected requests must not disturb the memory address.
                if (!acc_err) mem_addr <= {req_addr[MEM_WIDTH-1:3], 3'b000};
            end
            if (state == ST_RD0) buf0 <= mem_rd_data;
            if (state == ST_RD1) buf1 <= mem_rd_data;
            if (state_nxt == ST_RD1) mem_addr <= {dw_next, 3'b000};
            if (state_nxt == ST_RSP) begin
                rsp_error <= (state == ST_IDLE);
                rsp_rdata <= (state == ST_RD0 || state == ST_RD1) ? ld_data : '0;
            end
        end
    end

    // The final read beat's data is used straight off the bus for the response.
    assign ld_lo = (state == ST_RD0) ? mem_rd_data : buf0;
    assign ld_hi = (state == ST_RD1) ? mem_rd_data : buf1;

    dmem_lane_align #(
        .MLEN (MLEN),
        .XLEN (XLEN)
    ) u_align (
        .off     (lat_off),
        .size    (lat_f3[1:0]),
        .zext    (lat_f3[2]),
        .wdata   (lat_wdata),
        .buf0    (buf0),
        .buf1    (buf1),
        .ld_lo   (ld_lo),
        .ld_hi   (ld_hi),
        .beat0   (beat0),
        .beat1   (beat1),
        .ld_data (ld_data)
    );

    assign req_ready   = (state == ST_IDLE);
    assign rsp_valid   = (state == ST_RSP);
    assign mem_wr_en   = (state == ST_WR0) || (state == ST_WR1);
    assign mem_wr_data = (state == ST_WR1) ? beat1 : beat0;
    assign mem_funct3  = DMEM_F3_DWORD;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized traffic
// compared against a byte-level reference memory model.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [14:0] mem_addr;
    logic [2:0]  mem_funct3;
    logic [63:0] mem_rd_data;
    logic [63:0] mem_wr_data;
    logic        mem_wr_en;

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk         (clk),
        .areset      (areset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .mem_addr    (mem_addr),
        .mem_funct3  (mem_funct3),
        .mem_rd_data (mem_rd_data),
        .mem_wr_data (mem_wr_data),
        .mem_wr_en   (mem_wr_en)
    );

    int tests_run = 0;
    int tests_failed = 0;

    function automatic logic [7:0] init_byte(int i);
        if (i >= 'h08 && i <= 'h0F) return 8'h00;
        if (i >= 'h10 && i <= 'h17) return 8'(8'h11 * (i - 'h0F));
        return 8'((i * 37) ^ (i >> 5));
    endfunction

    // Environment memory: async read, commit on the rising edge of a write cycle.
    logic [7:0]  dmem [0:32767];
    bit          preloaded = 0;
    logic [14:0] wr_a_q[$];
    logic [63:0] wr_d_q[$];

    always_comb begin
        for (int b = 0; b < 8; b++)
            mem_rd_data[b*8 +: 8] = dmem[{mem_addr[14:3], 3'(b)}];
    end

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 32768; i++) dmem[i] = init_byte(i);
            preloaded = 1;
        end else if (mem_wr_en) begin
            wr_a_q.push_back(mem_addr);
            wr_d_q.push_back(mem_wr_data);
            for (int b = 0; b < 8; b++)
                dmem[{mem_addr[14:3], 3'(b)}] = mem_wr_data[b*8 +: 8];
        end
    end

    // Reference model: flat byte array updated by spec-level rules.
    logic [7:0]  rmem [0:32767];
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_nwr;
    logic [14:0] exp_wa [2];
    logic [63:0] exp_wd [2];

    function automatic logic [63:0] rdword(int base);
        logic [63:0] v = 64'h0;
        for (int b = 0; b < 8; b++) v[b*8 +: 8] = rmem[base + b];
        return v;
    endfunction

    task automatic model(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        int n, o, dw;
        bit sp;
        logic [31:0] v;
        n  = 1 << f3[1:0];
        o  = int'(a[2:0]);
        dw = int'(a[14:3]);
        sp = (o + n) > 8;
        exp_err = (f3[1:0] == 2'b11) || (f3 == 3'b110) || (f3 == 3'b111)
                || (we && f3[2]) || (a[31:15] != 0) || (sp && dw == 4095);
        exp_rdata = 32'h0;
        exp_nwr   = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (!we) begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = v | (32'(rmem[int'(a[14:0]) + k]) << (8 * k));
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            exp_rdata = v;
            exp_lat   = sp ? 3 : 2;
        end else begin
            for (int k = 0; k < n; k++) rmem[int'(a[14:0]) + k] = wd[8*k +: 8];
            exp_lat   = sp ? 5 : 3;
            exp_nwr   = sp ? 2 : 1;
            exp_wa[0] = 15'(dw * 8);
            exp_wd[0] = rdword(dw * 8);
            if (sp) begin
                exp_wa[1] = 15'((dw + 1) * 8);
                exp_wd[1] = rdword((dw + 1) * 8);
            end
        end
    endtask

    int          got_lat;
    logic [31:0] got_rdata;
    logic        got_err;
    logic        got_rdy_after;
    logic        got_vld_after;
    logic [31:0] got_rdata_after;
    bit          got_busy_ok;

    // Issue one request, wait (bounded) for the response, capture what was seen.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        model(we, f3, a, wd);
        wr_a_q.delete();
        wr_d_q.delete();
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        req_we     = 1'($urandom);
        got_lat     = -1;
        got_busy_ok = 1;
        got_rdata   = 32'hx;
        got_err     = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (req_ready) got_busy_ok = 0;
            if (rsp_valid) begin
                got_lat   = c;
                got_rdata = rsp_rdata;
                got_err   = rsp_error;
                break;
            end
        end
        @(negedge clk);
        got_rdy_after   = req_ready;
        got_vld_after   = rsp_valid;
        got_rdata_after = rsp_rdata;
    endtask

    task automatic test_reset;
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: ready=%b valid=%b wr_en=%b, required 1 0 0",
                     req_ready, rsp_valid, mem_wr_en);
        end
        tests_run++;
        if (rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || mem_addr !== 15'h0) begin
            tests_failed++;
            $display("FAIL reset_data: rdata=%h err=%b addr=%h, required 0 0 0",
                     rsp_rdata, rsp_error, mem_addr);
        end
        tests_run++;
        if (mem_funct3 !== 3'b011) begin
            tests_failed++;
            $display("FAIL mem_funct3: got %b, required 011", mem_funct3);
        end
    endtask

    task automatic test_aligned_load;
        do_req(1'b0, 3'b010, 32'h14, 32'h0);
        tests_run++;
        if (got_rdata !== 32'h88776655 || got_lat != 2 || got_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL lw_aligned: rdata=%h lat=%0d err=%b, required 88776655 2 0",
                     got_rdata, got_lat, got_err);
        end
        tests_run++;
        if (wr_a_q.size() != 0) begin
            tests_failed++;
            $display("FAIL lw_no_write: %0d strobes, required 0", wr_a_q.size());
        end
        tests_run++;
        if (!got_busy_ok || got_rdy_after !== 1'b1 || got_vld_after !== 1'b0
            || got_rdata_after !== 32'h88776655) begin
            tests_failed++;
            $display("FAIL handshake: busy_ok=%0d ready_after=%b valid_after=%b rdata_after=%h, required 1 1 0 88776655",
                     got_busy_ok, got_rdy_after, got_vld_after, got_rdata_after);
        end
    endtask

    task automatic test_extension;
        do_req(1'b0, 3'b000, 32'h17, 32'h0);
        tests_run++;
        if (got_rdata !== 32'hFFFFFF88 || got_lat != 2) begin
            tests_failed++;
            $display("FAIL lb_sign: rdata=%h lat=%0d, required ffffff88 2", got_rdata, got_lat);
        end
        do_req(1'b0, 3'b100, 32'h17, 32'h0);
        tests_run++;
        if (got_rdata !== 32'h00000088 || got_lat != 2) begin
            tests_failed++;
            $display("FAIL lbu_zero: rdata=%h lat=%0d, required 00000088 2", got_rdata, got_lat);
        end
        do_req(1'b0, 3'b001, 32'h16, 32'h0);
        tests_run++;
        if (got_rdata !== 32'hFFFF8877 || got_lat != 2) begin
            tests_failed++;
            $display("FAIL lh_sign: rdata=%h lat=%0d, required ffff8877 2", got_rdata, got_lat);
        end
    endtask

    task automatic test_subword_store;
        do_req(1'b1, 3'b000, 32'h11, 32'h000000AB);
        tests_run++;
        if (wr_a_q.size() != 1 || got_lat != 3 || got_rdata !== 32'h0 || got_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_rsp: writes=%0d lat=%0d rdata=%h err=%b, required 1 3 0 0",
                     wr_a_q.size(), got_lat, got_rdata, got_err);
        end else begin
            tests_run++;
            if (wr_a_q[0] !== 15'h10 || wr_d_q[0] !== 64'h887766554433AB11) begin
                tests_failed++;
                $display("FAIL sb_merge: addr=%h data=%h, required 0010 887766554433ab11",
                         wr_a_q[0], wr_d_q[0]);
            end
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        tests_run++;
        if (got_rdata !== 32'h4433AB11) begin
            tests_failed++;
            $display("FAIL sb_readback: rdata=%h, required 4433ab11", got_rdata);
        end
    endtask

    task automatic test_split;
        do_req(1'b1, 3'b010, 32'h0E, 32'hDEADBEEF);
        tests_run++;
        if (wr_a_q.size() != 2 || got_lat != 5) begin
            tests_failed++;
            $display("FAIL sw_split_rsp: writes=%0d lat=%0d, required 2 5", wr_a_q.size(), got_lat);
        end else begin
            tests_run++;
            if (wr_a_q[0] !== 15'h08 || wr_d_q[0] !== 64'hBEEF000000000000
                || wr_a_q[1] !== 15'h10 || wr_d_q[1] !== 64'h887766554433DEAD) begin
                tests_failed++;
                $display("FAIL sw_split_beats: %h:%h %h:%h, required 0008:beef000000000000 0010:887766554433dead",
                         wr_a_q[0], wr_d_q[0], wr_a_q[1], wr_d_q[1]);
            end
        end
        do_req(1'b0, 3'b010, 32'h0E, 32'h0);
        tests_run++;
        if (got_rdata !== 32'hDEADBEEF || got_lat != 3) begin
            tests_failed++;
            $display("FAIL lw_split: rdata=%h lat=%0d, required deadbeef 3", got_rdata, got_lat);
        end
    endtask

    task automatic test_errors;
        logic        we_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3_t [4] = '{3'b011, 3'b100, 3'b010, 3'b010};
        logic [31:0] a_t  [4] = '{32'h10, 32'h10, 32'h8000, 32'h7FFE};
        for (int i = 0; i < 4; i++) begin
            do_req(we_t[i], f3_t[i], a_t[i], 32'hFFFFFFFF);
            tests_run++;
            if (got_err !== 1'b1 || got_rdata !== 32'h0 || got_lat != 1 || wr_a_q.size() != 0) begin
                tests_failed++;
                $display("FAIL error_case%0d: err=%b rdata=%h lat=%0d writes=%0d, required 1 0 1 0",
                         i, got_err, got_rdata, got_lat, wr_a_q.size());
            end
        end
    endtask

    task automatic test_reset_mid;
        bit seen = 0;
        wr_a_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h1E; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_wr_en) begin seen = 1; break; end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL rst_mid_wr0: no write strobe seen within 10 cycles, required one");
        end
        areset = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || mem_wr_en !== 1'b0 || rsp_valid !== 1'b0
            || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || mem_addr !== 15'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: ready=%b wr_en=%b valid=%b rdata=%h err=%b addr=%h, required 1 0 0 0 0 0",
                     req_ready, mem_wr_en, rsp_valid, rsp_rdata, rsp_error, mem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        areset = 1'b0;
        tests_run++;
        if (wr_a_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rst_mid_nowrite: %0d strobes committed, required 0", wr_a_q.size());
        end
        do_req(1'b0, 3'b010, 32'h1E, 32'h0);
        tests_run++;
        if (got_rdata !== exp_rdata || got_lat != 3 || got_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_reload: rdata=%h lat=%0d err=%b, required %h 3 0",
                     got_rdata, got_lat, got_err, exp_rdata);
        end
    endtask

    task automatic test_random;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;
        logic [2:0]  ld_ok [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we)                   f3 = 3'($urandom_range(0, 2));
            else                           f3 = ld_ok[$urandom_range(0, 4)];
            r = $urandom_range(0, 15);
            if (r == 0)      a = 32'h7FF8 + 32'($urandom_range(0, 7));
            else if (r == 1) a = 32'($urandom) | 32'h8000;
            else             a = 32'h100 + 32'($urandom_range(0, 63));
            do_req(we, f3, a, $urandom);
            tests_run++;
            if (got_err !== exp_err || got_rdata !== exp_rdata || got_lat != exp_lat) begin
                tests_failed++;
                $display("FAIL rand%0d_rsp: we=%b f3=%b a=%h err=%b rdata=%h lat=%0d, required %b %h %0d",
                         i, we, f3, a, got_err, got_rdata, got_lat, exp_err, exp_rdata, exp_lat);
            end
            tests_run++;
            if (wr_a_q.size() != exp_nwr) begin
                tests_failed++;
                $display("FAIL rand%0d_nwr: %0d strobes, required %0d", i, wr_a_q.size(), exp_nwr);
            end else begin
                for (int w = 0; w < exp_nwr; w++) begin
                    tests_run++;
                    if (wr_a_q[w] !== exp_wa[w] || wr_d_q[w] !== exp_wd[w]) begin
                        tests_failed++;
                        $display("FAIL rand%0d_beat%0d: %h:%h, required %h:%h",
                                 i, w, wr_a_q[w], wr_d_q[w], exp_wa[w], exp_wd[w]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) rmem[i] = init_byte(i);
        repeat (3) @(negedge clk);
        test_reset();
        areset = 1'b0;
        @(negedge clk);
        test_aligned_load();
        test_extension();
        test_subword_store();
        test_split();
        test_errors();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
